// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Buffer entries are fixed at 32-bit pc/inst fields.
package ifetch_unit_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FULL
    } ifetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect request and instruction delivery handshake.
// master is the fetch unit, slave is the memory/core side.
interface ifetch_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-3:0] imem_addr_out;
    logic [WIDTH-1:0] imem_data_in;
    logic             redirect_valid_in;
    logic [WIDTH-1:0] redirect_pc_in;
    logic             inst_valid_out;
    logic [WIDTH-1:0] inst_out;
    logic [WIDTH-1:0] inst_pc_out;
    logic             inst_ready_in;

    modport master (
        output imem_addr_out,
        input  imem_data_in,
        input  redirect_valid_in,
        input  redirect_pc_in,
        output inst_valid_out,
        output inst_out,
        output inst_pc_out,
        input  inst_ready_in
    );

    modport slave (
        input  imem_addr_out,
        output imem_data_in,
        output redirect_valid_in,
        output redirect_pc_in,
        input  inst_valid_out,
        input  inst_out,
        input  inst_pc_out,
        output inst_ready_in
    );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Instruction buffer: circular queue of DEPTH fetch entries with push/pop/flush.
// Head is read straight from storage, so a pushed entry is visible one cycle later.
module ifetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  ifetch_entry_t push_entry,
    input  logic          pop,
    input  logic          flush,
    output ifetch_entry_t head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    ifetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok     = pop & (count != '0);
    assign push_ok    = push & ((count != CW'(DEPTH)) | pop_ok);
    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a small buffer with redirect and backpressure.
// Optional macro IFETCH_PERF_EN adds the fetch_count_out push counter port.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]  fetch_count_out
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    ifetch_state_t    state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target_pc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    ifetch_entry_t    head;
    ifetch_entry_t    wr_entry;
    logic             head_valid;
    logic             redirect;
    logic             pop;
    logic             push;

    assign redirect  = bus.redirect_valid_in;
    assign target_pc = {bus.redirect_pc_in[WIDTH-1:2], 2'b00};
    assign pop       = head_valid & bus.inst_ready_in;
    // RUN implies free space, so a push there never overflows; FULL needs the pop.
    assign push      = ~redirect & ((state == RUN) | ((state == FULL) & pop));
    assign wr_entry  = '{pc: 32'(pc), inst: 32'(bus.imem_data_in)};

    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    if (redirect) begin
                        pc <= target_pc;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc    <= target_pc;
                        state <= RUN;
                    end else begin
                        if (push) begin
                            pc <= pc + WIDTH'(4);
                        end
                        state <= (count_next == CW'(DEPTH)) ? FULL : RUN;
                    end
                end
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.imem_addr_out  = pc[WIDTH-1:2];
    assign bus.inst_valid_out = head_valid;
    assign bus.inst_out       = head_valid ? WIDTH'(head.inst) : WIDTH'(NOP);
    assign bus.inst_pc_out    = head_valid ? WIDTH'(head.pc) : '0;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_out <= '0;
        end else if (push) begin
            fetch_count_out <= fetch_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_unit_if #(.WIDTH(32)) bus ();

    // Instruction memory: word value derived from its byte address.
    assign bus.imem_data_in = 32'h1000_0000 + {bus.imem_addr_out, 2'b00};

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    ifetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count_out (fetch_count)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ment_t;

    ment_t       q[$];
    logic [31:0] mpc;
    bit          mboot;
    int unsigned mfetch;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc    = 32'h0000_0000;
        mboot  = 1'b1;
        mfetch = 0;
    endtask

    // One clock edge of the fetch rules, written over a plain queue.
    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit space;
        pop   = (q.size() > 0) && rdy;
        space = (q.size() < DEPTH) || pop;
        if (mboot) begin
            mboot = 1'b0;
            if (rv) mpc = rpc & 32'hFFFF_FFFC;
        end else if (rv) begin
            q.delete();
            mpc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(q.pop_front());
            if (space) begin
                q.push_back('{pc: mpc, inst: 32'h1000_0000 + mpc});
                mpc = mpc + 32'd4;
                mfetch++;
            end
        end
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() > 0);
        check("valid", 32'(bus.inst_valid_out), 32'(v));
        check("inst", bus.inst_out, v ? q[0].inst : NOP);
        check("inst_pc", bus.inst_pc_out, v ? q[0].pc : 32'h0);
        check("imem_addr", {2'b00, bus.imem_addr_out}, {2'b00, mpc[31:2]});
`ifdef IFETCH_PERF_EN
        check("fetch_count", fetch_count, mfetch);
`endif
    endtask

    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        check_all();
        bus.redirect_valid_in = rv;
        bus.redirect_pc_in    = rpc;
        bus.inst_ready_in     = rdy;
        model_step(rv, rpc, rdy);
        @(posedge clk);
    endtask

    task automatic head_is(input string tag, input logic [31:0] pc);
        #1;
        check({tag, "_valid"}, 32'(bus.inst_valid_out), 32'd1);
        check({tag, "_pc"}, bus.inst_pc_out, pc);
        check({tag, "_inst"}, bus.inst_out, 32'h1000_0000 + pc);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.redirect_valid_in = 1'b0;
        bus.inst_ready_in     = 1'b0;
        #1;
        check("rst_valid", 32'(bus.inst_valid_out), 32'd0);
        check("rst_inst", bus.inst_out, 32'h0000_0013);
        check("rst_pc", bus.inst_pc_out, 32'h0);
        check("rst_imem_addr", {2'b00, bus.imem_addr_out}, 32'h0);
`ifdef IFETCH_PERF_EN
        check("rst_fetch_count", fetch_count, 32'h0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = 32'h0;
        bus.inst_ready_in     = 1'b0;
        model_reset();
        do_reset();

        // Streaming from reset with ready held high.
        step(1'b0, 32'h0, 1'b1);
        #1 check("boot_empty", 32'(bus.inst_valid_out), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        head_is("stream0", 32'h0);
        step(1'b0, 32'h0, 1'b1);
        head_is("stream1", 32'h4);
        step(1'b0, 32'h0, 1'b1);
        head_is("stream2", 32'h8);
        step(1'b0, 32'h0, 1'b1);
        head_is("stream3", 32'hC);

        // Backpressure: buffer saturates, PC stalls, nothing is lost.
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0);
        #1 check("stall_imem_addr", {2'b00, bus.imem_addr_out}, 32'h2);
        head_is("stall_head0", 32'h0);
        step(1'b0, 32'h0, 1'b1);
        head_is("stall_head1", 32'h4);
        step(1'b0, 32'h0, 1'b1);
        head_is("stall_head2", 32'h8);

        // Redirect to an unaligned target while full.
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0);
        #1 check("redir_flush", 32'(bus.inst_valid_out), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        head_is("redir_target", 32'h0000_0100);

        // PC wraps past the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        head_is("wrap0", 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        head_is("wrap1", 32'h0000_0000);
        step(1'b0, 32'h0, 1'b1);
        head_is("wrap2", 32'h0000_0004);

        // Redirect arriving in the boot cycle.
        do_reset();
        step(1'b1, 32'h0000_0040, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        head_is("boot_redirect", 32'h0000_0040);

        // Asynchronous reset with two entries buffered, then restart.
        repeat (3) step(1'b0, 32'h0, 1'b0);
        #1 check("pre_rst_valid", 32'(bus.inst_valid_out), 32'd1);
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        head_is("restart", 32'h0);

        // Ten pushes around one redirect.
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);
`ifdef IFETCH_PERF_EN
        #1 check("perf_count", fetch_count, 32'd10);
`endif

        // Random traffic against the model.
        repeat (400) begin
            step(($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        check_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
